// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU/load writebacks onto the register file write port
// and tracks pending writes so the issue stage can stall on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int NREGS      = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_ra,
    input  logic [ADDR_W-1:0] issue_rb,
    output logic              issue_stall,
    output logic [ADDR_W-1:0] write_Rd,
    output logic [DATA_W-1:0] write_data,
    output logic [NREGS-1:0]  busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] write_rd_q, write_rd_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              alu_grant, mem_grant;

    always_comb begin
        alu_grant   = rst_n && alu_valid && (!mem_valid || starve_q == SMAX);
        mem_grant   = rst_n && mem_valid && !alu_grant;
        alu_ready   = alu_grant;
        mem_ready   = mem_grant;
        issue_stall = !rst_n || (issue_valid &&
                      (busy_q[issue_ra] || busy_q[issue_rb] || busy_q[issue_rd]));
    end

    always_comb begin
        starve_d     = (!alu_valid || alu_grant) ? '0 :
                       (starve_q == SMAX ? SMAX : starve_q + SW'(1));
        write_rd_d   = alu_grant ? alu_rd : (mem_grant ? mem_rd : '0);
        write_data_d = alu_grant ? alu_data : (mem_grant ? mem_data : '0);
        busy_d       = busy_q;
        // Commit clear first so a same-edge issue to that register keeps it busy.
        if (write_rd_q != '0)
            busy_d[write_rd_q] = 1'b0;
        if (issue_valid && !issue_stall && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q     <= '0;
            write_rd_q   <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            starve_q     <= starve_d;
            write_rd_q   <= write_rd_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign write_Rd   = write_rd_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
endmodule
